// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings, ALU operation enum and ID-stage bundles shared by the decode slice
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } alu_op_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      mem_to_reg;
    logic      alu_src;
    logic      branch;
    logic      branch_ne;
    logic      jump;
    logic      jump_reg;
    logic      link;
    alu_op_e   alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    ctrl_t       ctrl;
    logic        illegal;
  } idex_t;

endpackage

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two async read ports with write-through, one sync write port
module reg_file #(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);
  logic [31:0] regs_q [32];
  logic        wr_ok;
  // $0 is never written and is cleared by reset, so reads of it need no special case
  assign wr_ok = we_i && !(ZERO_REG && waddr_i == 5'd0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end
  assign rdata_a_o = (wr_ok && waddr_i == raddr_a_i) ? wdata_i : regs_q[raddr_a_i];
  assign rdata_b_o = (wr_ok && waddr_i == raddr_b_i) ? wdata_i : regs_q[raddr_b_i];
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS decode, register read, load-use detection and ID/EX pipeline register
module id_stage
  import mips_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction_in,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  output logic        hazard_out,
  output logic        illegal_out,
  output logic [31:0] pc_out,
  output logic [31:0] rs_data_out,
  output logic [31:0] rt_data_out,
  output logic [31:0] imm_out,
  output logic [31:0] branch_target_out,
  output logic [31:0] jump_target_out,
  output logic [4:0]  rs_out,
  output logic [4:0]  rt_out,
  output logic [4:0]  dest_out,
  output logic        reg_write_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        mem_to_reg_out,
  output logic        alu_src_out,
  output logic        branch_out,
  output logic        branch_ne_out,
  output logic        jump_out,
  output logic        jump_reg_out,
  output logic        link_out,
  output logic [3:0]  alu_op_out
);
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dest;
  logic [31:0] rs_data, rt_data, sext, imm, pc4;
  logic        illegal, uses_rs, uses_rt;
  ctrl_t       ctrl;
  idex_t       idex_d, idex_q;
  assign op    = instruction_in[31:26];
  assign rs    = instruction_in[25:21];
  assign rt    = instruction_in[20:16];
  assign rd    = instruction_in[15:11];
  assign funct = instruction_in[5:0];
  assign sext  = {{16{instruction_in[15]}}, instruction_in[15:0]};
  assign pc4   = pc_in + 32'd4;
  reg_file #(.ZERO_REG(ZERO_REG)) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data)
  );
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    dest    = rt;
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    imm     = sext;
    case (op)
      OP_RTYPE: begin
        dest           = rd;
        uses_rt        = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:          ctrl.alu_op = ALU_AND;
          FN_OR:           ctrl.alu_op = ALU_OR;
          FN_XOR:          ctrl.alu_op = ALU_XOR;
          FN_NOR:          ctrl.alu_op = ALU_NOR;
          FN_SLT:          ctrl.alu_op = ALU_SLT;
          FN_SLTU:         ctrl.alu_op = ALU_SLTU;
          FN_SLL: begin
            ctrl.alu_op = ALU_SLL;
            uses_rs     = 1'b0;
          end
          FN_SRL: begin
            ctrl.alu_op = ALU_SRL;
            uses_rs     = 1'b0;
          end
          FN_SRA: begin
            ctrl.alu_op = ALU_SRA;
            uses_rs     = 1'b0;
          end
          FN_JR: begin
            ctrl.reg_write = 1'b0;
            ctrl.jump_reg  = 1'b1;
            uses_rt        = 1'b0;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = op == OP_SLTI  ? ALU_SLT  :
                         op == OP_SLTIU ? ALU_SLTU :
                         op == OP_ANDI  ? ALU_AND  :
                         op == OP_ORI   ? ALU_OR   :
                         op == OP_XORI  ? ALU_XOR  :
                         op == OP_LUI   ? ALU_LUI  : ALU_ADD;
        imm            = (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? {16'h0, instruction_in[15:0]} :
                         op == OP_LUI ? {instruction_in[15:0], 16'h0} : sext;
        uses_rs        = op != OP_LUI;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = op == OP_BNE;
        ctrl.alu_op    = ALU_SUB;
        uses_rt        = 1'b1;
      end
      OP_J, OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.link      = op == OP_JAL;
        ctrl.reg_write = op == OP_JAL;
        dest           = 5'd31;
        uses_rs        = 1'b0;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl    = '0;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
    end
    // a write to the hardwired zero register is no write at all, which makes sll $0,$0,0 a clean no-op
    if (ZERO_REG && dest == 5'd0) ctrl.reg_write = 1'b0;
    if (!ctrl.reg_write) dest = 5'd0;
  end
  assign hazard_out = ex_mem_read && ex_rt != 5'd0 &&
                      ((uses_rs && rs == ex_rt) || (uses_rt && rt == ex_rt));
  always_comb begin
    idex_d               = '0;
    idex_d.pc            = pc_in;
    idex_d.rs_data       = rs_data;
    idex_d.rt_data       = rt_data;
    idex_d.imm           = imm;
    idex_d.branch_target = pc4 + {sext[29:0], 2'b00};
    idex_d.jump_target   = {pc4[31:28], instruction_in[25:0], 2'b00};
    idex_d.rs            = rs;
    idex_d.rt            = rt;
    idex_d.dest          = dest;
    idex_d.ctrl          = ctrl;
    idex_d.illegal       = illegal;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else if (flush) idex_q <= '0;
    else if (!stall) idex_q <= hazard_out ? '0 : idex_d;
  end
  assign pc_out            = idex_q.pc;
  assign rs_data_out       = idex_q.rs_data;
  assign rt_data_out       = idex_q.rt_data;
  assign imm_out           = idex_q.imm;
  assign branch_target_out = idex_q.branch_target;
  assign jump_target_out   = idex_q.jump_target;
  assign rs_out            = idex_q.rs;
  assign rt_out            = idex_q.rt;
  assign dest_out          = idex_q.dest;
  assign illegal_out       = idex_q.illegal;
  assign reg_write_out     = idex_q.ctrl.reg_write;
  assign mem_read_out      = idex_q.ctrl.mem_read;
  assign mem_write_out     = idex_q.ctrl.mem_write;
  assign mem_to_reg_out    = idex_q.ctrl.mem_to_reg;
  assign alu_src_out       = idex_q.ctrl.alu_src;
  assign branch_out        = idex_q.ctrl.branch;
  assign branch_ne_out     = idex_q.ctrl.branch_ne;
  assign jump_out          = idex_q.ctrl.jump;
  assign jump_reg_out      = idex_q.ctrl.jump_reg;
  assign link_out          = idex_q.ctrl.link;
  assign alu_op_out        = idex_q.ctrl.alu_op;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors for id_stage, checked every cycle against a mnemonic-level model plus literal expectations
module tb_id_stage;
  import mips_pkg::*;
  logic        clk = 1'b0;
  logic        rst, stall, flush, wb_en, ex_mem_read, run;
  logic [31:0] pc_in, instruction_in, wb_data;
  logic [4:0]  wb_addr, ex_rt;
  logic        hazard_out, illegal_out;
  logic [31:0] pc_out, rs_data_out, rt_data_out, imm_out, branch_target_out, jump_target_out;
  logic [4:0]  rs_out, rt_out, dest_out;
  logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, alu_src_out;
  logic        branch_out, branch_ne_out, jump_out, jump_reg_out, link_out;
  logic [3:0]  alu_op_out;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .pc_in(pc_in), .instruction_in(instruction_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .hazard_out(hazard_out), .illegal_out(illegal_out),
    .pc_out(pc_out), .rs_data_out(rs_data_out), .rt_data_out(rt_data_out),
    .imm_out(imm_out), .branch_target_out(branch_target_out), .jump_target_out(jump_target_out),
    .rs_out(rs_out), .rt_out(rt_out), .dest_out(dest_out),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_to_reg_out(mem_to_reg_out), .alu_src_out(alu_src_out), .branch_out(branch_out),
    .branch_ne_out(branch_ne_out), .jump_out(jump_out), .jump_reg_out(jump_reg_out),
    .link_out(link_out), .alu_op_out(alu_op_out)
  );

  typedef struct packed {
    logic [31:0] pc, rsd, rtd, imm, bt, jt;
    logic [4:0]  rs, rt, dest;
    logic        rw, mr, mw, m2r, asrc, br, bne, j, jr, link, ill;
    logic [3:0]  alu;
  } exp_t;

  exp_t        q = '0;
  logic [31:0] regs [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string mnem(input logic [31:0] i);
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h00: return "sll";   6'h02: return "srl";  6'h03: return "sra";  6'h08: return "jr";
        6'h20: return "add";   6'h21: return "addu"; 6'h22: return "sub";  6'h23: return "subu";
        6'h24: return "and";   6'h25: return "or";   6'h26: return "xor";  6'h27: return "nor";
        6'h2A: return "slt";   6'h2B: return "sltu";
        default: return "ill";
      endcase
    end
    case (i[31:26])
      6'h02: return "j";     6'h03: return "jal";   6'h04: return "beq";  6'h05: return "bne";
      6'h08: return "addi";  6'h09: return "addiu"; 6'h0A: return "slti"; 6'h0B: return "sltiu";
      6'h0C: return "andi";  6'h0D: return "ori";   6'h0E: return "xori"; 6'h0F: return "lui";
      6'h23: return "lw";    6'h2B: return "sw";
      default: return "ill";
    endcase
  endfunction

  function automatic alu_op_e alu_of(input string m);
    if (m == "sub" || m == "subu" || m == "beq" || m == "bne") return ALU_SUB;
    if (m == "and" || m == "andi") return ALU_AND;
    if (m == "or" || m == "ori") return ALU_OR;
    if (m == "xor" || m == "xori") return ALU_XOR;
    if (m == "nor") return ALU_NOR;
    if (m == "slt" || m == "slti") return ALU_SLT;
    if (m == "sltu" || m == "sltiu") return ALU_SLTU;
    if (m == "sll") return ALU_SLL;
    if (m == "srl") return ALU_SRL;
    if (m == "sra") return ALU_SRA;
    if (m == "lui") return ALU_LUI;
    return ALU_ADD;
  endfunction

  function automatic exp_t exp_of(input logic [31:0] i, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    string       m;
    logic [31:0] se, pc4;
    logic [4:0]  d;
    bit          rtype;
    m     = mnem(i);
    rtype = i[31:26] == 6'h00;
    se    = {{16{i[15]}}, i[15:0]};
    pc4   = pc + 32'd4;
    e     = '0;
    e.pc  = pc;
    e.rsd = a;
    e.rtd = b;
    e.rs  = i[25:21];
    e.rt  = i[20:16];
    e.imm = (m == "andi" || m == "ori" || m == "xori") ? {16'h0, i[15:0]} :
            (m == "lui") ? {i[15:0], 16'h0} : se;
    e.bt  = pc4 + se * 32'd4;
    e.jt  = {pc4[31:28], i[25:0], 2'b00};
    e.ill = m == "ill";
    if (e.ill) return e;
    d      = rtype ? i[15:11] : (m == "jal") ? 5'd31 : i[20:16];
    e.rw   = !(m == "sw" || m == "beq" || m == "bne" || m == "j" || m == "jr") && d != 5'd0;
    e.dest = e.rw ? d : 5'd0;
    e.mr   = m == "lw";
    e.m2r  = m == "lw";
    e.mw   = m == "sw";
    e.asrc = !rtype && !(m == "beq" || m == "bne" || m == "j" || m == "jal");
    e.br   = m == "beq" || m == "bne";
    e.bne  = m == "bne";
    e.j    = m == "j" || m == "jal";
    e.jr   = m == "jr";
    e.link = m == "jal";
    e.alu  = alu_of(m);
    return e;
  endfunction

  function automatic logic hz_of(input logic [31:0] i, input logic er, input logic [4:0] ert);
    string m;
    bit    reads_rs, reads_rt;
    m        = mnem(i);
    reads_rs = !(m == "ill" || m == "j" || m == "jal" || m == "lui" || m == "sll" || m == "srl" || m == "sra");
    reads_rt = m != "ill" && ((i[31:26] == 6'h00 && m != "jr") || m == "sw" || m == "beq" || m == "bne");
    return er && ert != 5'd0 && ((reads_rs && i[25:21] == ert) || (reads_rt && i[20:16] == ert));
  endfunction

  function automatic logic [31:0] rdm(input logic [4:0] addr);
    return (wb_en && wb_addr == addr && addr != 5'd0) ? wb_data : regs[addr];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
      for (int k = 0; k < 32; k++) regs[k] <= '0;
    end else begin
      if (flush) q <= '0;
      else if (!stall) q <= hz_of(instruction_in, ex_mem_read, ex_rt) ? '0 :
                            exp_of(instruction_in, pc_in, rdm(instruction_in[25:21]), rdm(instruction_in[20:16]));
      if (wb_en && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("hazard", 32'(hazard_out), 32'(hz_of(instruction_in, ex_mem_read, ex_rt)));
      chk("pc", pc_out, q.pc);
      chk("rs_data", rs_data_out, q.rsd);
      chk("rt_data", rt_data_out, q.rtd);
      chk("imm", imm_out, q.imm);
      chk("branch_target", branch_target_out, q.bt);
      chk("jump_target", jump_target_out, q.jt);
      chk("rs", 32'(rs_out), 32'(q.rs));
      chk("rt", 32'(rt_out), 32'(q.rt));
      chk("dest", 32'(dest_out), 32'(q.dest));
      chk("ctrl", 32'({reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, alu_src_out,
                       branch_out, branch_ne_out, jump_out, jump_reg_out, link_out, illegal_out}),
                  32'({q.rw, q.mr, q.mw, q.m2r, q.asrc, q.br, q.bne, q.j, q.jr, q.link, q.ill}));
      chk("alu_op", 32'(alu_op_out), 32'(q.alu));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] ins);
    pc_in          = pc;
    instruction_in = ins;
  endtask

  logic [31:0] table_ins [10] = '{32'h2022FFFE, 32'h8C440008, 32'hAC44000C, 32'h14640003, 32'h08000040,
                                  32'h03E00008, 32'h00031103, 32'h0043082A, 32'h2CC50007, 32'h01093827};

  initial begin
    run = 1'b0; stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    ex_mem_read = 1'b0; ex_rt = '0; pc_in = '0; instruction_in = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    run = 1'b1;
    #2;
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_ctrl", 32'({reg_write_out, jump_out, illegal_out, alu_op_out}), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_en = 1'b0;
    issue(32'h100, 32'h00A53020);
    tick();
    chk("bypass_rs", rs_data_out, 32'hDEADBEEF);
    chk("bypass_rt", rt_data_out, 32'hDEADBEEF);
    chk("bypass_dest", 32'(dest_out), 32'd6);
    chk("bypass_alu", 32'(alu_op_out), 32'(ALU_ADD));
    chk("bypass_pc", pc_out, 32'h100);
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234;
    issue(32'h104, 32'h01004820);
    tick();
    chk("same_cycle_fwd", rs_data_out, 32'h1234);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    issue(32'h108, 32'h00000820);
    tick();
    wb_en = 1'b0;
    chk("zero_fwd", rs_data_out, 32'h0);
    tick();
    chk("zero_read", rt_data_out, 32'h0);
    issue(32'h10C, 32'h00000000);
    tick();
    chk("nop_rw", 32'({reg_write_out, illegal_out, dest_out}), 32'h0);
    issue(32'h40, 32'h1022FFFF);
    tick();
    chk("beq_target", branch_target_out, 32'h40);
    chk("beq_flags", 32'({branch_out, reg_write_out}), 32'b10);
    ex_mem_read = 1'b1; ex_rt = 5'd9;
    issue(32'h200, 32'h01215020);
    #1 chk("loaduse_hazard", 32'(hazard_out), 32'd1);
    tick();
    chk("loaduse_bubble", 32'({pc_out[15:0], reg_write_out, dest_out}), 32'h0);
    ex_mem_read = 1'b0;
    tick();
    chk("loaduse_release", pc_out, 32'h200);
    ex_mem_read = 1'b1; stall = 1'b1;
    issue(32'h204, 32'h01215020);
    tick();
    chk("stall_hold_pc", pc_out, 32'h200);
    chk("stall_hold_dest", 32'(dest_out), 32'd10);
    flush = 1'b1;
    tick();
    chk("flush_pc", pc_out, 32'h0);
    chk("flush_ctrl", 32'({reg_write_out, dest_out, rs_data_out[7:0]}), 32'h0);
    flush = 1'b0; stall = 1'b0; ex_mem_read = 1'b0;
    issue(32'h10000000, 32'h0C000010);
    tick();
    chk("jal_target", jump_target_out, 32'h10000040);
    chk("jal_link", 32'({link_out, jump_out, reg_write_out, dest_out}), 32'({3'b111, 5'd31}));
    issue(32'h300, 32'hFC000000);
    tick();
    chk("illegal_flag", 32'(illegal_out), 32'd1);
    chk("illegal_ctrl", 32'({reg_write_out, mem_read_out, mem_write_out, branch_out, jump_out, alu_op_out}), 32'h0);
    issue(32'h304, 32'h30838000);
    tick();
    chk("andi_zext", imm_out, 32'h00008000);
    issue(32'h308, 32'h3C071234);
    tick();
    chk("lui_imm", imm_out, 32'h12340000);
    issue(32'h30C, 32'h0000003F);
    tick();
    chk("bad_funct", 32'(illegal_out), 32'd1);
    for (int k = 0; k < 10; k++) begin
      wb_en = 1'b1; wb_addr = 5'(16 + k); wb_data = 32'h11111111 * (k + 1);
      issue(32'h400 + 32'(k * 4), table_ins[k]);
      tick();
    end
    wb_en = 1'b0;
    issue(32'h500, 32'h01004820);
    tick();
    chk("pre_rst_rs", rs_data_out, 32'h1234);
    rst = 1'b1;
    #1;
    chk("async_rst_pc", pc_out, 32'h0);
    chk("async_rst_rs", rs_data_out, 32'h0);
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h55;
    tick();
    rst = 1'b0; wb_en = 1'b0;
    issue(32'h504, 32'h01856820);
    tick();
    chk("rst_write_dropped", rs_data_out, 32'h0);
    chk("rst_cleared_5", rt_data_out, 32'h0);
    issue(32'h508, 32'h01004820);
    tick();
    chk("rst_cleared_8", rs_data_out, 32'h0);
    tick();
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter ZERO_REG, default 1; when 1, register 0 reads as 0 and ignores writes.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 stall  in  1  hold ID/EX register and register-file read path.
REQ-005 flush  in  1  load bubble into ID/EX register.
REQ-006 pc_in  in  32  PC of the fetched instruction, from the IF/ID register.
REQ-007 instruction_in  in  32  fetched instruction word, from the IF/ID register.
REQ-008 wb_en, wb_addr, wb_data  in  1/5/32  writeback port into the register file.
REQ-009 ex_mem_read, ex_rt  in  1/5  load in EX and its destination, for load-use detection.
REQ-010 hazard_out  out  1  combinational load-use stall request.
REQ-011 illegal_out  out  1  registered; undecodable instruction.
REQ-012 pc_out, rs_data_out, rt_data_out, imm_out, branch_target_out, jump_target_out  out  32 each  registered.
REQ-013 rs_out, rt_out, dest_out  out  5 each  registered register indices.
REQ-014 reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, alu_src_out, branch_out, branch_ne_out, jump_out, jump_reg_out, link_out  out  1 each  registered control signals.
REQ-015 alu_op_out  out  4  registered ALU operation code.

Function
REQ-016 Register file: 32x32, synchronous write on wb_en, asynchronous read of rs=[25:21] and rt=[20:16].
REQ-017 A same-cycle write to the address being read SHALL forward wb_data to the read result (write-through); address 0 is excluded when ZERO_REG=1.
REQ-018 Decode covers:
  - R-type op 0x00 with funct add/addu/sub/subu/and/or/xor/nor/slt/sltu/sll/srl/sra/jr;
  - addi/addiu/slti/sltiu/andi/ori/xori/lui/lw/sw/beq/bne/j/jal.
REQ-019 Any other opcode/funct SHALL produce all control signals 0 and illegal_out=1.
REQ-020 imm_out: zero-extended for andi/ori/xori, {imm,16'b0} for lui, sign-extended otherwise.
REQ-021 branch_target_out = pc_in + 4 + (sext(imm) << 2), modulo 2^32.
REQ-022 jump_target_out = {pc_in+4 [31:28], instr[25:0], 2'b00}.
REQ-023 dest_out: rd for R-type, rt for I-type, 31 for jal.
REQ-024 dest_out: 0 with reg_write_out=0 for sw, beq, bne, j and jr.
REQ-025 link_out=1 only for jal.
REQ-026 hazard_out=1 iff ex_mem_read and ex_rt!=0 and ex_rt matches a source register the instruction actually reads (rs, or rt for R-type/sw/beq/bne).
REQ-027 ID/EX update priority: rst > flush > stall > hazard_out > normal load.
REQ-028 flush SHALL load the bubble: all outputs 0.
REQ-029 stall SHALL hold all registered outputs; register-file writes still occur during stall.
REQ-030 With hazard_out=1 and stall=0, the ID/EX register SHALL load the bubble; upstream must hold the IF/ID register.
REQ-031 Otherwise the ID/EX register SHALL load the decode results; latency is 1 cycle from instruction_in to outputs.
REQ-032 instruction_in=0 (sll $0,$0,0) SHALL decode as a legal no-op with reg_write_out=0, since dest is 0.

Reset
REQ-033 rst SHALL clear every registered output and all 32 register-file entries to 0, immediately and independent of clk.
REQ-034 A wb_en write coincident with rst SHALL be discarded.

Structure
REQ-035 Shared package mips_pkg SHALL hold opcode/funct constants, the alu_op enum and a control-bundle struct.
REQ-036 The alu_op enum: ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI.
REQ-037 The register file SHALL be one sub-module, reg_file, instantiated inside id_stage.
REQ-038 Decode SHALL be combinational logic in id_stage.

Verification
REQ-039 Write/read bypass: write $5=0xDEADBEEF via wb, then instruction_in=0x00A53020 (add $6,$5,$5), pc_in=0x100 -> next edge rs_data_out=rt_data_out=0xDEADBEEF, dest_out=6, alu_op=ADD, pc_out=0x100.
REQ-040 Same-cycle forwarding: wb writes $8=0x1234 while decoding a reader of $8 -> rs_data_out=0x1234.
REQ-041 $0 behaviour: a write of $0 followed by a read of $0 -> 0.
REQ-042 Branch: pc_in=0x40, beq $1,$2,-1 (0x1022FFFF) -> branch_target_out=0x40, branch_out=1, reg_write_out=0.
REQ-043 Load-use: ex_mem_read=1, ex_rt=9, instruction reads rs=9 -> hazard_out=1 and bubble loaded.
REQ-044 Load-use repeat with stall=1 -> outputs hold.
REQ-045 Flush/reset/illegal:
  - flush=1 during stall=1 -> all outputs 0;
  - rst pulse mid-stream -> outputs and registers 0 without a clock edge;
  - opcode 0x3F -> illegal_out=1 with control 0.
